seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter DW, default 4, sets the dividend and quotient width in bits.
REQ-002 Parameter VW, default 2, sets the divisor and remainder width in bits; VW <= DW SHALL hold.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n, input, 1, reset; it SHALL be synchronous and active-low.
REQ-005 Port start, input, 1, requests one division; sampled only in IDLE.
REQ-006 Port dividend, input, DW, unsigned dividend; sampled on the accepted start.
REQ-007 Port divisor, input, VW, unsigned divisor; sampled on the accepted start.
REQ-008 Port quotient, output, DW, unsigned quotient, registered.
REQ-009 Port remainder, output, VW, unsigned remainder, registered.
REQ-010 Port busy, output, 1, high while an iteration is in progress.
REQ-011 Port done, output, 1, one-cycle pulse marking valid results.
REQ-012 Port dbz, output, 1, divide-by-zero flag for the last completed operation.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE, with a 2-bit state register.
REQ-014 IDLE SHALL transition:
- start=1 and divisor!=0 -> BUSY.
- start=1 and divisor==0 -> DONE.
- otherwise -> IDLE.
REQ-015 On the accepted start edge the block SHALL latch the dividend into a DW-bit shift register and the divisor into a VW-bit register, clear a (VW+1)-bit partial remainder, and load an iteration counter with DW.
REQ-016 Each BUSY cycle SHALL perform one restoring step:
- Shift {partial remainder, dividend register} left by one.
- Compute trial = partial remainder - {0, divisor} at VW+1 bits.
- Trial non-negative: keep trial and set the shifted-in quotient bit to 1.
- Trial negative: restore and set the quotient bit to 0.
REQ-017 BUSY SHALL last exactly DW cycles; the counter decrements each step, and the step at count 1 transitions to DONE.
REQ-018 DONE SHALL last one cycle, assert done=1, and return to IDLE unconditionally.
REQ-019 With start accepted at edge k and a nonzero divisor:
- busy=1 from edge k+1 through edge k+DW.
- done=1 for the cycle after edge k+DW+1.
- Total latency is DW+1 cycles.
REQ-020 quotient and remainder SHALL update only on the transition into DONE, and hold until the next completion or reset.
REQ-021 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
REQ-022 Divisor==0 on an accepted start SHALL give:
- quotient = all ones, remainder = 0, dbz = 1, busy never asserted.
- done at edge k+1.
REQ-023 dbz SHALL be cleared on every completion with a nonzero divisor.
REQ-024 start asserted in BUSY or DONE SHALL be ignored; no queuing.
REQ-025 Changes to dividend or divisor after acceptance SHALL NOT affect the running operation.
REQ-026 start held high continuously SHALL launch a new operation on each return to IDLE, one cycle after done.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force:
- state = IDLE.
- quotient = 0, remainder = 0, busy = 0, done = 0, dbz = 0.
- Counter and internal registers cleared.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse; results SHALL read 0.
REQ-029 A start presented on the first edge with rst_n=1 SHALL be accepted.

Verification
REQ-030 13/3 (DW=4, VW=2) -> quotient=4, remainder=1, dbz=0; done exactly 5 cycles after start; busy high for 4 cycles.
REQ-031 Boundary cases SHALL give:
- 15/1 -> quotient=15, remainder=0.
- 2/3 -> quotient=0, remainder=2.
- 0/2 -> quotient=0, remainder=0.
REQ-032 9/0 -> done 1 cycle after start, quotient=15, remainder=0, dbz=1, busy stays 0; a following 6/2 -> quotient=3, remainder=0, dbz=0.
REQ-033 Start 14/3, then pulse start with 5/1 and change the operand inputs during BUSY -> quotient=4, remainder=2; exactly one done pulse.
REQ-034 Start 15/2, then assert rst_n=0 at the 2nd BUSY cycle -> no done pulse; all outputs 0 the next cycle; a new 7/2 -> quotient=3, remainder=1.
REQ-035 Exhaustive sweep over all 64 dividend/divisor pairs, self-checked against a reference divide, with REQ-021 and REQ-019 timing asserted on every operation.

Source files
------------

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, DW steps per operation.
// Divide-by-zero completes immediately with an all-ones quotient and the dbz flag set.
module seq_div #(
  parameter int DW = 4,
  parameter int VW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          dbz
);

  // state | meaning
  // IDLE  | waiting for start
  // BUSY  | one restoring step per cycle, DW cycles
  // DONE  | one-cycle done pulse, results valid
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   prem_q, prem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;
  logic          qbit;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    // The extra top bit makes a negative trial visible as its sign bit.
    shifted = {prem_q, dvd_q[DW-1]};
    trial   = shifted - {2'b00, dvs_q};
    qbit    = ~trial[VW+1];

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          prem_d = '0;
          cnt_d  = CW'(DW);
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        dvd_d  = {dvd_q[DW-2:0], qbit};
        prem_d = qbit ? trial[VW:0] : shifted[VW:0];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quo_d   = dvd_d;
          rem_d   = prem_d[VW-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = (state_q == BUSY);
  assign done      = (state_q == DONE);
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: timeline-based reference model compared every cycle,
// directed literal cases, an exhaustive operand sweep and randomized traffic with resets.
module tb_seq_div;
  localparam int DW = 4;
  localparam int VW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
  logic          done;
  logic          dbz;

  int total = 0;
  int bad   = 0;

  seq_div #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation is described by the edge numbers at which
  // busy, the results and done must appear, plus the edge from which a new start is taken.
  int            cyc       = 0;
  int            free_at   = 0;
  int            busy_from = -1;
  int            busy_to   = -2;
  int            done_at   = -1;
  int            apply_at  = -1;
  logic [DW-1:0] pend_q, exp_q;
  logic [VW-1:0] pend_r, exp_r;
  logic          pend_dbz, exp_dbz, exp_busy, exp_done;
  bit            model_ok  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q = '0; exp_r = '0; exp_dbz = 1'b0;
      busy_from = -1; busy_to = -2; done_at = -1; apply_at = -1;
      free_at = cyc + 1;
    end else begin
      if (cyc >= free_at && start) begin
        if (divisor != 0) begin
          pend_q    = DW'(dividend / DW'(divisor));
          pend_r    = VW'(dividend % DW'(divisor));
          pend_dbz  = 1'b0;
          busy_from = cyc + 1;
          busy_to   = cyc + DW;
          done_at   = cyc + DW + 1;
        end else begin
          pend_q   = '1;
          pend_r   = '0;
          pend_dbz = 1'b1;
          done_at  = cyc + 1;
        end
        apply_at = done_at - 1;
        free_at  = done_at + 1;
      end
      if (cyc == apply_at) begin
        exp_q = pend_q; exp_r = pend_r; exp_dbz = pend_dbz;
      end
    end
    exp_busy = (cyc + 1 >= busy_from) && (cyc + 1 <= busy_to);
    exp_done = (cyc + 1 == done_at);
    model_ok = 1'b1;
    cyc++;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model busy", busy, exp_busy);
      chk("model done", done, exp_done);
      chk("model quotient", quotient, exp_q);
      chk("model remainder", remainder, exp_r);
      chk("model dbz", dbz, exp_dbz);
    end
  end

  task automatic launch(input int a, input int b);
    @(negedge clk);
    start = 1'b1; dividend = DW'(a); divisor = VW'(b);
  endtask

  // Drops start, scrambles operands, then waits (bounded) for done and checks the result.
  task automatic finish_op(input string name, input int a, input int b, input int eq,
                           input int er, input int edbz, input int elat, input int ebusy);
    int n = 0;
    int nb = 0;
    bit seen = 1'b0;
    @(negedge clk);
    start = 1'b0; dividend = DW'($urandom); divisor = VW'($urandom);
    for (int i = 1; i <= 20 && !seen; i++) begin
      if (busy) nb++;
      if (done) begin
        seen = 1'b1;
        n = i;
      end else begin
        @(negedge clk);
      end
    end
    chk({name, " latency"}, n, elat);
    chk({name, " busy cycles"}, nb, ebusy);
    chk({name, " quotient"}, quotient, eq);
    chk({name, " remainder"}, remainder, er);
    chk({name, " dbz"}, dbz, edbz);
    if (b != 0) begin
      chk({name, " identity"}, quotient * b + remainder, a);
      chk({name, " rem<div"}, remainder < b, 1);
    end
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dbz", dbz, 0);

    // start on the very first edge out of reset
    rst_n = 1'b1; start = 1'b1; dividend = 4'd13; divisor = 2'd3;
    finish_op("13/3", 13, 3, 4, 1, 0, 5, 4);

    launch(15, 1); finish_op("15/1", 15, 1, 15, 0, 0, 5, 4);
    launch(2, 3);  finish_op("2/3", 2, 3, 0, 2, 0, 5, 4);
    launch(0, 2);  finish_op("0/2", 0, 2, 0, 0, 0, 5, 4);
    launch(9, 0);  finish_op("9/0", 9, 0, 15, 0, 1, 1, 0);
    launch(6, 2);  finish_op("6/2", 6, 2, 3, 0, 0, 5, 4);

    // start pulse and operand changes during BUSY are ignored
    launch(14, 3);
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = (i == 2); dividend = 4'd5; divisor = 2'd1;
      if (done) begin
        ndone++;
        chk("14/3 quotient", quotient, 4);
        chk("14/3 remainder", remainder, 2);
      end
    end
    chk("14/3 done pulses", ndone, 1);

    // reset during the second BUSY cycle aborts the operation
    launch(15, 2);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort dbz", dbz, 0);
    rst_n = 1'b1;
    launch(7, 2); finish_op("7/2", 7, 2, 3, 1, 0, 5, 4);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        launch(a, b);
        if (b != 0) finish_op("sweep", a, b, a / b, a % b, 0, 5, 4);
        else        finish_op("sweep", a, b, 15, 0, 1, 1, 0);
      end
    end

    // start held high: back-to-back operations, checked by the model
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'b1; dividend = DW'($urandom); divisor = VW'($urandom);
    end

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 2) != 0);
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
      rst_n    = ($urandom_range(0, 60) != 0);
    end

    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
